// File: rtl/ones_count_accumulator_pkg.sv
// Shared definitions for the ones-count frame accumulator: FSM states and default sizing.
package ones_count_accumulator_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int unsigned DEF_WINDOWS = 8;
    localparam int unsigned DEF_SUM_W   = 5;
    localparam int unsigned DEF_THRESH  = 12;

endpackage

// File: rtl/ones_count_accumulator_frame_counter.sv
// Group counter for one frame: counts accepted groups and flags the last one of the frame.
module frame_counter
    import ones_count_accumulator_pkg::*;
#(
    parameter int unsigned WINDOWS = DEF_WINDOWS
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic clr,
    output logic last
);

    localparam int unsigned CNT_W = (WINDOWS > 1) ? $clog2(WINDOWS) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last = (cnt_q == CNT_W'(WINDOWS - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ones_count_accumulator.sv
// Sums 2-bit ones counts over a frame of WINDOWS accepted groups; reports total, done pulse
// and a threshold flag.
module ones_count_accumulator
    import ones_count_accumulator_pkg::*;
#(
    parameter int unsigned WINDOWS = DEF_WINDOWS,
    parameter int unsigned SUM_W   = DEF_SUM_W,
    parameter int unsigned THRESH  = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             y0,
    input  logic             y1,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic             above
);

    if (WINDOWS < 1 || WINDOWS > 255) begin : g_bad_windows
        $error("WINDOWS must be in 1..255");
    end
    if ((64'd1 << SUM_W) <= 64'(3 * WINDOWS)) begin : g_bad_sum_w
        $error("SUM_W too narrow for 3*WINDOWS");
    end

    state_t           state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             above_q, above_d;
    logic [SUM_W-1:0] grp;
    logic             accept;
    logic             last;
    logic             cnt_clr;

    assign grp      = SUM_W'({y1, y0});
    assign busy     = (state_q == S_ACCUM);
    assign in_ready = busy & ~clear;
    assign accept   = in_valid & in_ready;
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign above    = above_q;

    frame_counter #(
        .WINDOWS(WINDOWS)
    ) u_frame_counter (
        .clk  (clk),
        .rstn (rstn),
        .en   (accept),
        .clr  (cnt_clr),
        .last (last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        above_d = above_q;
        cnt_clr = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            sum_d   = '0;
            above_d = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // A start in the DONE cycle opens the next frame directly
                    if (start) begin
                        state_d = S_ACCUM;
                        acc_d   = '0;
                        sum_d   = '0;
                        above_d = 1'b0;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc_d = acc_q + grp;
                        if (last) begin
                            state_d = S_DONE;
                            sum_d   = acc_d;
                            above_d = (32'(acc_d) >= THRESH);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            above_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            above_q <= above_d;
        end
    end

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Bench for ones_count_accumulator: a WINDOWS=8 and a WINDOWS=1 instance share stimulus from
// an upstream ones counter and are compared every cycle against a frame-level model.
module tb_ones_count_accumulator;

    logic clk = 1'b0;
    logic rstn;
    logic start, clear, in_valid;
    logic a, b, c;
    logic [1:0] ycnt;
    logic y0, y1;

    logic busy_o[2], ready_o[2], done_o[2], above_o[2];
    logic [4:0] sum0;
    logic [2:0] sum1;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt0 = 0;

    // upstream 3-input ones counter
    assign ycnt = {1'b0, a} + {1'b0, b} + {1'b0, c};
    assign y0 = ycnt[0];
    assign y1 = ycnt[1];

    always #5 clk = ~clk;

    ones_count_accumulator #(.WINDOWS(8), .SUM_W(5), .THRESH(12)) dut0 (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear), .in_valid(in_valid),
        .y0(y0), .y1(y1), .in_ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]),
        .sum(sum0), .above(above_o[0])
    );

    ones_count_accumulator #(.WINDOWS(1), .SUM_W(3), .THRESH(12)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear), .in_valid(in_valid),
        .y0(y0), .y1(y1), .in_ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]),
        .sum(sum1), .above(above_o[1])
    );

    // frame-level model: a frame is a list of accepted counts; its total is reported once full
    int  win[2] = '{8, 1};
    bit  m_prog[2];
    bit  m_done[2];
    int  m_sum[2];
    bit  m_above[2];
    int  frame_q[2][$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                m_prog[i] = 0; m_done[i] = 0; m_sum[i] = 0; m_above[i] = 0;
                frame_q[i].delete();
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_done[i] = 0;
                if (clear) begin
                    m_prog[i] = 0; m_sum[i] = 0; m_above[i] = 0;
                    frame_q[i].delete();
                end else if (!m_prog[i]) begin
                    if (start) begin
                        m_prog[i] = 1; m_sum[i] = 0; m_above[i] = 0;
                        frame_q[i].delete();
                    end
                end else if (in_valid) begin
                    frame_q[i].push_back(int'(ycnt));
                    if (frame_q[i].size() == win[i]) begin
                        int tot;
                        tot = 0;
                        foreach (frame_q[i][k]) tot += frame_q[i][k];
                        m_sum[i] = tot;
                        m_above[i] = (tot >= 12);
                        m_prog[i] = 0;
                        m_done[i] = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(m_prog[i]));
                check($sformatf("in_ready[%0d]", i), int'(ready_o[i]), int'(m_prog[i] & ~clear));
                check($sformatf("done[%0d]", i), int'(done_o[i]), int'(m_done[i]));
                check($sformatf("sum[%0d]", i), (i == 0) ? int'(sum0) : int'(sum1), m_sum[i]);
                check($sformatf("above[%0d]", i), int'(above_o[i]), int'(m_above[i]));
            end
            if (done_o[0]) done_cnt0++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] abc, input logic v, input logic st);
        {a, b, c} = abc;
        in_valid = v;
        start = st;
        tick();
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int d_before;
        rstn = 1'b0; start = 0; clear = 0; in_valid = 0; {a, b, c} = 3'b000;
        #12 rstn = 1'b1;
        tick();

        // T1: async reset in the middle of a frame
        drive(3'b000, 0, 1);
        for (int i = 0; i < 3; i++) drive(3'b111, 1, 0);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("t1_sum0", int'(sum0), 0);
        check("t1_busy0", int'(busy_o[0]), 0);
        check("t1_ready0", int'(ready_o[0]), 0);
        check("t1_done1", int'(done_o[1]), 0);
        check("t1_sum1", int'(sum1), 0);
        @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        check("t1_post_busy0", int'(busy_o[0]), 0);
        check("t1_post_ready0", int'(ready_o[0]), 0);

        // T2: full frame of 111
        drive(3'b000, 0, 1);
        for (int i = 0; i < 8; i++) drive(3'b111, 1, 0);
        check("t2_done", int'(done_o[0]), 1);
        check("t2_sum", int'(sum0), 24);
        check("t2_above", int'(above_o[0]), 1);
        check("t2_model_sum", m_sum[0], 24);
        tick();

        // T3: stalls between groups; counts 1,2,0,2,3,3,1,2
        d_before = done_cnt0;
        drive(3'b000, 0, 1);
        drive(3'b001, 1, 0); drive(3'b011, 1, 0); drive(3'b000, 1, 0); drive(3'b110, 1, 0);
        drive(3'b111, 0, 0); drive(3'b111, 1, 0); drive(3'b010, 0, 0);
        drive(3'b111, 1, 0); drive(3'b100, 1, 0);
        drive(3'b111, 0, 0); drive(3'b011, 0, 0); drive(3'b101, 1, 0);
        check("t3_sum", int'(sum0), 14);
        check("t3_above", int'(above_o[0]), 1);
        check("t3_model_sum", m_sum[0], 14);
        tick(); tick();
        check("t3_done_once", done_cnt0 - d_before, 1);

        // T4: clear after 5 accepts, then a frame of zeros
        d_before = done_cnt0;
        drive(3'b000, 0, 1);
        for (int i = 0; i < 5; i++) drive(3'($urandom_range(7)), 1, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4_busy", int'(busy_o[0]), 0);
        check("t4_sum", int'(sum0), 0);
        check("t4_no_done", done_cnt0 - d_before, 0);
        drive(3'b000, 0, 1);
        for (int i = 0; i < 8; i++) drive(3'b000, 1, 0);
        check("t4_zero_sum", int'(sum0), 0);
        check("t4_zero_above", int'(above_o[0]), 0);
        check("t4_zero_done", int'(done_o[0]), 1);

        // T5: start ignored during ACCUM, honoured in DONE for a back-to-back frame
        tick();
        drive(3'b000, 0, 1);
        for (int i = 0; i < 3; i++) drive(3'($urandom_range(7)), 1, 0);
        drive(3'($urandom_range(7)), 1, 1);
        check("t5_still_busy", int'(busy_o[0]), 1);
        for (int i = 0; i < 4; i++) drive(3'($urandom_range(7)), 1, 0);
        check("t5_done1", int'(done_o[0]), 1);
        drive(3'b000, 0, 1);
        check("t5_restart_busy", int'(busy_o[0]), 1);
        for (int i = 0; i < 8; i++) drive(3'b010, 1, 0);
        check("t5_frame2_sum", int'(sum0), 8);
        check("t5_frame2_above", int'(above_o[0]), 0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            clear = ($urandom_range(19) == 0);
            drive(3'($urandom_range(7)), 1'($urandom_range(3) != 0), 1'($urandom_range(5) == 0));
            clear = 1'b0;
        end

        // T6: WINDOWS=1 instance, single accept of 110
        clear = 1'b1;
        tick();
        clear = 1'b0;
        drive(3'b000, 0, 1);
        drive(3'b110, 1, 0);
        check("t6_done", int'(done_o[1]), 1);
        check("t6_sum", int'(sum1), 2);
        check("t6_above", int'(above_o[1]), 0);
        check("t6_model_sum", m_sum[1], 2);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
